// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: UART transmitter mapped into a 16-byte window on the single-cycle core's data bus.
// Define UART_PARITY_EN to append an even-parity bit after the eight data bits of every frame.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR = 32'h810,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

`ifdef UART_PARITY_EN
    localparam logic PAR_EN = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    localparam logic PAR_EN = 1'b0;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] divShadow_q, divShadow_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  txData_q, txData_d;
    logic        ovr_q, ovr_d;
    logic        wrEn;
    logic [1:0]  regSel;
    logic        unusedBits;

    assign hit        = (adr[31:4] == BASE_ADDR[31:4]);
    assign regSel     = adr[3:2];
    assign wrEn       = we & hit;
    assign busy       = (state_q != IDLE);
    assign unusedBits = ^{re, adr[1:0], wdata[31:16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            div_q       <= DIV_RESET;
            divShadow_q <= 16'd0;
            baudCnt_q   <= 16'd0;
            bitIdx_q    <= 3'd0;
            txData_q    <= 8'd0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            divShadow_q <= divShadow_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            txData_q    <= txData_d;
            ovr_q       <= ovr_d;
        end
    end

    // The frame runs off divShadow_q so a DIV store mid-frame only affects the next frame.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        divShadow_d = divShadow_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        txData_d    = txData_q;
        ovr_d       = ovr_q;

        if (wrEn && regSel == 2'd2) begin
            div_d = wdata[15:0];
        end
        if (wrEn && regSel == 2'd1 && wdata[2]) begin
            ovr_d = 1'b0;
        end

        if (state_q == IDLE) begin
            if (wrEn && regSel == 2'd0) begin
                state_d     = START;
                txData_d    = wdata[7:0];
                divShadow_d = div_q;
                baudCnt_d   = 16'd0;
                bitIdx_d    = 3'd0;
            end
        end else begin
            if (wrEn && regSel == 2'd0) begin
                ovr_d = 1'b1;
            end
            if (baudCnt_q == divShadow_q) begin
                baudCnt_d = 16'd0;
                case (state_q)
                    START: state_d = DATA;
                    DATA: begin
                        if (bitIdx_q == 3'd7) begin
                            bitIdx_d = 3'd0;
`ifdef UART_PARITY_EN
                            state_d  = PARITY;
`else
                            state_d  = STOP;
`endif
                        end else begin
                            bitIdx_d = bitIdx_q + 3'd1;
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: state_d = STOP;
`endif
                    default: state_d = IDLE;
                endcase
            end else begin
                baudCnt_d = baudCnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START: tx = 1'b0;
            DATA:  tx = txData_q[bitIdx_q];
`ifdef UART_PARITY_EN
            PARITY: tx = ^txData_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (regSel)
                2'd0:    rdata = {24'd0, txData_q};
                2'd1:    rdata = {28'd0, PAR_EN, ovr_q, busy, ~busy};
                2'd2:    rdata = {16'd0, div_q};
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a bit-level frame model.
// Honours UART_PARITY_EN so the same bench covers both builds.
module tb_mmio_uart_tx;

`ifdef UART_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif
    localparam int          F    = PAR ? 11 : 10;
    localparam logic [31:0] BASE = 32'h810;

    logic        clk;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [15:0] modelDiv;
    logic [7:0]  modelTx;
    logic        modelOvr;

    mmio_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .adr   (adr),
        .wdata (wdata),
        .we    (we),
        .re    (re),
        .hit   (hit),
        .rdata (rdata),
        .tx    (tx),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Line level of frame slot idx: start, eight data bits LSB first, optional parity, stop.
    function automatic logic modelBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic logic [31:0] statusExp(input logic b);
        return {28'd0, PAR, modelOvr, b, ~b};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic wr);
        adr   = addr;
        wdata = data;
        we    = wr;
        re    = ~wr;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic modelBusy);
        applyStimulus(addr, data, 1'b1);
        if (addr[31:4] == BASE[31:4]) begin
            case (addr[3:2])
                2'd0: if (modelBusy) modelOvr = 1'b1; else modelTx = data[7:0];
                2'd1: if (data[2]) modelOvr = 1'b0;
                2'd2: modelDiv = data[15:0];
                default: ;
            endcase
        end
    endtask

    task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        adr = addr;
        we  = 1'b0;
        re  = 1'b1;
        #1;
        checkOutput(tag, rdata, expected);
    endtask

    // Starts a frame and watches every clock of it; an optional extra store lands at cycle midCycle.
    task automatic runFrame(input string tag, input logic [7:0] b, input int midCycle,
                            input logic [31:0] midAdr, input logic [31:0] midData);
        int frameDiv, len, mc, badTx, badStat;
        frameDiv = int'(modelDiv);
        len      = F * (frameDiv + 1);
        mc       = (midCycle >= len) ? len - 1 : midCycle;
        badTx    = 0;
        badStat  = 0;
        busWrite(BASE, {24'd0, b}, 1'b0);
        for (int k = 0; k < len; k++) begin
            adr = BASE + 32'h4;
            re  = 1'b1;
            #1;
            if (tx !== modelBit(b, k / (frameDiv + 1))) badTx++;
            if (busy !== 1'b1 || rdata !== statusExp(1'b1)) badStat++;
            if (k == mc) busWrite(midAdr, midData, 1'b1);
            else begin
                @(posedge clk);
                #1;
            end
        end
        checkOutput({tag, " tx bad cycles"}, 32'(badTx), 32'd0);
        checkOutput({tag, " busy/status bad cycles"}, 32'(badStat), 32'd0);
        adr = BASE + 32'h4;
        #1;
        checkOutput({tag, " idle tx"}, {31'd0, tx}, 32'd1);
        checkOutput({tag, " idle status"}, rdata, statusExp(1'b0));
    endtask

    initial begin
        logic [7:0]  rb;
        logic [31:0] rd;
        int          mc;

        reset = 1'b1;
        adr   = 32'd0;
        wdata = 32'd0;
        we    = 1'b0;
        re    = 1'b0;
        modelDiv = 16'd433;
        modelTx  = 8'd0;
        modelOvr = 1'b0;
        #2;
        checkOutput("reset tx", {31'd0, tx}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset values");
        readCheck("div reset", BASE + 32'h8, {16'd0, modelDiv});
        readCheck("status reset", BASE + 32'h4, statusExp(1'b0));
        readCheck("txdata reset", BASE, {24'd0, modelTx});
        readCheck("reserved read", BASE + 32'hC, 32'd0);
        checkOutput("hit in window", {31'd0, hit}, 32'd1);

        $display("[TB] 0x55 at DIV=3");
        busWrite(BASE + 32'h8, 32'd3, 1'b0);
        runFrame("f55", 8'h55, -1, 32'd0, 32'd0);

        $display("[TB] back-to-back store at DIV=0");
        busWrite(BASE + 32'h8, 32'd0, 1'b0);
        runFrame("fA3", 8'hA3, 0, BASE, 32'h11);
        readCheck("txdata keeps A3", BASE, {24'd0, modelTx});
        busWrite(BASE + 32'h4, 32'h0, 1'b0);
        readCheck("status noop write", BASE + 32'h4, statusExp(1'b0));
        busWrite(BASE + 32'h4, 32'h4, 1'b0);
        readCheck("status ovr cleared", BASE + 32'h4, statusExp(1'b0));

        $display("[TB] DIV change mid-frame");
        busWrite(BASE + 32'h8, 32'd1, 1'b0);
        runFrame("fFF", 8'hFF, 5, BASE + 32'h8, 32'd7);
        readCheck("div after mid write", BASE + 32'h8, {16'd0, modelDiv});
        runFrame("f00", 8'h00, -1, 32'd0, 32'd0);

        $display("[TB] reset mid-frame");
        busWrite(BASE + 32'h8, 32'd3, 1'b0);
        busWrite(BASE, 32'h0F, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort tx", {31'd0, tx}, 32'd1);
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        modelDiv = 16'd433;
        modelTx  = 8'd0;
        modelOvr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post-abort tx", {31'd0, tx}, 32'd1);
        readCheck("div after abort", BASE + 32'h8, {16'd0, modelDiv});
        readCheck("status after abort", BASE + 32'h4, statusExp(1'b0));

        $display("[TB] out-of-window and reserved stores");
        busWrite(BASE + 32'hC, 32'hFFFF_FFFF, 1'b0);
        busWrite(32'h820, 32'h1, 1'b0);
        adr = 32'h820;
        #1;
        checkOutput("hit outside", {31'd0, hit}, 32'd0);
        checkOutput("rdata outside", rdata, 32'd0);
        checkOutput("busy after outside store", {31'd0, busy}, 32'd0);
        readCheck("div unchanged", BASE + 32'h8, {16'd0, modelDiv});
        readCheck("txdata unchanged", BASE, {24'd0, modelTx});
        readCheck("status unchanged", BASE + 32'h4, statusExp(1'b0));
        readCheck("reserved still 0", BASE + 32'hC, 32'd0);

        $display("[TB] randomized frames");
        for (int i = 0; i < 6; i++) begin
            busWrite(BASE + 32'h8, $urandom_range(0, 4), 1'b0);
            readCheck("rand div", BASE + 32'h8, {16'd0, modelDiv});
            rb = 8'($urandom);
            rd = $urandom;
            if (i == 0) mc = -1;
            else if (i == 1) mc = 1000;
            else mc = int'($urandom_range(0, 12)) - 2;
            runFrame("rand", rb, mc, BASE, rd);
            readCheck("rand txdata", BASE, {24'd0, modelTx});
            busWrite(BASE + 32'h4, 32'h4, 1'b0);
            readCheck("rand status clear", BASE + 32'h4, statusExp(1'b0));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
